// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one multi-cycle main memory between the I-cache and D-cache miss
// handlers. One requester is served at a time. A line fill is a pipelined
// burst of WORDS word reads. A store is a single-word write.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req/i_wr/i_addr/i_wdata   I-cache request (req held until i_done)
//   i_gnt/i_rvalid/i_done       I-cache grant, fill word valid, completion pulse
//   d_*                         same set of signals for the D-cache
//   rdata, word_idx             shared fill word and its index in the line
//   mem_en/mem_wr/mem_addr/mem_wdata   memory command (all zero when idle)
//   mem_rdata/mem_rvalid        memory read return, in order, any latency
module mem_arbiter #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [IDX_W-1:0]  word_idx,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ISSUE, S_DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_owner;
  logic              r_lastOwner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [IDX_W-1:0]  r_issueCnt;
  logic [IDX_W-1:0]  r_retCnt;

  logic              w_grant;
  logic              w_grantOwner;
  logic              w_grantWr;
  logic              w_ret;
  logic              w_lastRet;
  logic              w_done;
  logic              w_busy;

  // Next-state decode and memory command. The read address keeps the line
  // base of the latched request and replaces the word offset with the issue
  // counter, so a fill always starts at word 0 of the line. A burst ends on
  // the last in-order return rather than after a fixed count of cycles, which
  // keeps the arbiter independent of memory latency.
  always_comb begin
    w_nextState  = r_state;
    w_grant      = 1'b0;
    w_grantOwner = OWN_I;
    w_grantWr    = 1'b0;
    w_ret        = 1'b0;
    w_lastRet    = 1'b0;
    w_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_grant = 1'b1;
          // Under contention the requester not served last wins.
          if (i_req && d_req) begin
            w_grantOwner = ~r_lastOwner;
          end else begin
            w_grantOwner = d_req;
          end
          w_grantWr   = (w_grantOwner == OWN_D) ? d_wr : i_wr;
          w_nextState = w_grantWr ? S_WRITE : S_ISSUE;
        end
      end
      S_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        w_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      S_ISSUE: begin
        mem_en    = 1'b1;
        mem_addr  = {r_addr[ADDR_W-1:IDX_W+1], r_issueCnt, 1'b0};
        w_ret     = mem_rvalid;
        w_lastRet = mem_rvalid && (r_retCnt == LAST_IDX);
        if (w_lastRet) begin
          w_done      = 1'b1;
          w_nextState = S_IDLE;
        end else if (r_issueCnt == LAST_IDX) begin
          w_nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_ret     = mem_rvalid;
        w_lastRet = mem_rvalid && (r_retCnt == LAST_IDX);
        if (w_lastRet) begin
          w_done      = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Requester-facing outputs. Only the latched owner ever sees grant, valid
  // or done. Returns arriving in IDLE or WRITE are stale and are dropped.
  assign w_busy   = (r_state != S_IDLE);
  assign i_gnt    = w_busy && (r_owner == OWN_I);
  assign d_gnt    = w_busy && (r_owner == OWN_D);
  assign i_rvalid = w_ret && (r_owner == OWN_I);
  assign d_rvalid = w_ret && (r_owner == OWN_D);
  assign i_done   = w_done && (r_owner == OWN_I);
  assign d_done   = w_done && (r_owner == OWN_D);
  assign rdata    = w_ret ? mem_rdata : '0;
  assign word_idx = w_ret ? r_retCnt : '0;

  // State register and transaction context. The request is latched at grant
  // time so that later changes on the request inputs cannot disturb a burst
  // that memory has already accepted. The round-robin history is recorded at
  // grant time. Only one transaction runs at a time, so this matches the
  // history at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_I;
      r_lastOwner <= OWN_I;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_issueCnt  <= '0;
      r_retCnt    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_grant) begin
        r_owner     <= w_grantOwner;
        r_lastOwner <= w_grantOwner;
        r_addr      <= (w_grantOwner == OWN_D) ? d_addr : i_addr;
        r_wdata     <= (w_grantOwner == OWN_D) ? d_wdata : i_wdata;
        r_issueCnt  <= '0;
        r_retCnt    <= '0;
      end else begin
        if (r_state == S_ISSUE) begin
          r_issueCnt <= r_issueCnt + IDX_W'(1);
        end
        if (w_ret) begin
          r_retCnt <= r_retCnt + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Scoreboard bench for mem_arbiter. A behavioural memory with programmable
// in-order read latency sits behind the arbiter. Expected memory commands and
// expected fill returns are queued when a request is driven. A negedge monitor
// pops and compares them as the DUT produces them.
module tb_mem_arbiter;

  localparam int WORDS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_wr = 1'b0;
  logic [15:0] i_addr = '0;
  logic [15:0] i_wdata = '0;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        i_gnt, i_rvalid, i_done;
  logic        d_gnt, d_rvalid, d_done;
  logic [15:0] rdata;
  logic [2:0]  word_idx;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  int total = 0;
  int bad = 0;
  bit monEn = 1'b0;

  mem_arbiter #(.WORDS(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_done(d_done),
    .rdata(rdata), .word_idx(word_idx),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  // Background contents of memory: distinct for every word of a line.
  function automatic logic [15:0] patt(input logic [14:0] w);
    return {w[7:0], w[14:7]} ^ 16'hC3A5;
  endfunction

  // Behavioural memory. Reads are captured at the clock edge and returned in
  // order 'lat' cycles later. Returns still in flight keep coming out across a
  // reset, just as stale data from a real memory would.
  logic [15:0] memArr [0:32767];
  int lat = 1;
  longint cyc = 0;
  typedef struct packed { longint due; logic [15:0] data; } pend_t;
  pend_t pend[$];

  always @(posedge clk) begin : memModel
    pend_t p;
    if (mem_en && mem_wr) memArr[mem_addr[15:1]] = mem_wdata;
    if (mem_en && !mem_wr) begin
      p.due  = cyc + longint'(lat);
      p.data = memArr[mem_addr[15:1]];
      pend.push_back(p);
    end
    cyc = cyc + 1;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= pend[0].data;
      void'(pend.pop_front());
    end else begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 16'($urandom);
    end
  end

  // Scoreboard queues.
  typedef struct packed { logic wr; logic [15:0] addr; logic [15:0] wdata; } req_t;
  typedef struct packed { logic owner; logic [2:0] idx; logic [15:0] data; logic last; } ret_t;
  req_t expReq[$];
  ret_t expRet[$];

  // Queues the expected read commands and fill words of one line fill.
  // Owner 0 is the I-cache and owner 1 is the D-cache.
  task automatic pushFill(input logic owner, input logic [15:0] addr, input bit ovr,
                          input logic [2:0] ovrIdx, input logic [15:0] ovrVal);
    req_t q;
    ret_t r;
    logic [14:0] baseWord;
    baseWord = addr[15:1] & 15'h7FF8;
    for (int k = 0; k < WORDS; k++) begin
      q.wr    = 1'b0;
      q.addr  = (addr & 16'hFFF0) + 16'(2 * k);
      q.wdata = 16'h0000;
      expReq.push_back(q);
      r.owner = owner;
      r.idx   = 3'(k);
      r.data  = (ovr && (3'(k) == ovrIdx)) ? ovrVal : patt(baseWord + 15'(k));
      r.last  = (k == WORDS - 1);
      expRet.push_back(r);
    end
  endtask

  // Negedge monitor.
  always @(negedge clk) begin : monitor
    req_t eq;
    ret_t er;
    logic [3:0] expFlags;
    if (monEn && rst_n) begin
      total++;
      if (i_gnt && d_gnt) begin
        bad++;
        $display("[TB] FAIL gnt_exclusive: got i_gnt=%0b d_gnt=%0b, required at most one", i_gnt, d_gnt);
      end
      if (mem_en) begin
        total++;
        if (expReq.size() == 0) begin
          bad++;
          $display("[TB] FAIL mem_req: got wr=%0b addr=%h, required no access", mem_wr, mem_addr);
        end else begin
          eq = expReq.pop_front();
          if ({mem_wr, mem_addr, mem_wdata} !== {eq.wr, eq.addr, eq.wdata}) begin
            bad++;
            $display("[TB] FAIL mem_req: got wr=%0b addr=%h wdata=%h, required wr=%0b addr=%h wdata=%h",
                     mem_wr, mem_addr, mem_wdata, eq.wr, eq.addr, eq.wdata);
          end
        end
      end else begin
        total++;
        if ({mem_wr, mem_addr, mem_wdata} !== 33'b0) begin
          bad++;
          $display("[TB] FAIL mem_idle: got wr=%0b addr=%h wdata=%h, required all 0", mem_wr, mem_addr, mem_wdata);
        end
      end
      if (i_rvalid || d_rvalid) begin
        total++;
        if (expRet.size() == 0) begin
          bad++;
          $display("[TB] FAIL ret: got i_rvalid=%0b d_rvalid=%0b data=%h, required no return", i_rvalid, d_rvalid, rdata);
        end else begin
          er = expRet.pop_front();
          expFlags = {~er.owner, er.owner, ~er.owner & er.last, er.owner & er.last};
          if ({i_rvalid, d_rvalid, i_done, d_done, word_idx, rdata} !== {expFlags, er.idx, er.data}) begin
            bad++;
            $display("[TB] FAIL ret: got iv/dv/id/dd=%b idx=%0d data=%h, required %b idx=%0d data=%h",
                     {i_rvalid, d_rvalid, i_done, d_done}, word_idx, rdata, expFlags, er.idx, er.data);
          end
        end
      end
    end
  end

  // Waits a bounded number of cycles for n done pulses. It records the
  // sequence of owners in 'order', one bit per pulse (1 = D-cache).
  task automatic waitDones(input int n, input int budget, output int seen, output logic [7:0] order);
    seen = 0;
    order = '0;
    for (int k = 0; k < budget && seen < n; k++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        seen++;
        order = {order[6:0], d_done};
      end
    end
  endtask

  // Lets in-flight memory returns drain before the latency is changed.
  task automatic settle();
    for (int k = 0; k < 30 && pend.size() != 0; k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [58:0] outs;
    monEn = 1'b0;
    @(negedge clk);
    outs = {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_en, mem_wr,
            mem_addr, mem_wdata, rdata, word_idx};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_por: got outputs=%h, required 0", outs);
    end
    rst_n = 1'b1;
    lat = 4;
    i_req = 1'b1;
    i_addr = 16'h0100;
    repeat (4) @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || i_gnt !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_midburst_busy: got mem_en=%0b i_gnt=%0b, required 1 1", mem_en, i_gnt);
    end
    rst_n = 1'b0;
    #1;
    outs = {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_en, mem_wr,
            mem_addr, mem_wdata, rdata, word_idx};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("[TB] FAIL reset_midburst: got outputs=%h, required 0", outs);
    end
    i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total++;
      if ({i_rvalid, d_rvalid, i_gnt, d_gnt, mem_en} !== 5'b0) begin
        bad++;
        $display("[TB] FAIL reset_stale: got iv/dv/ig/dg/en=%b with mem_rvalid=%0b, required 00000",
                 {i_rvalid, d_rvalid, i_gnt, d_gnt, mem_en}, mem_rvalid);
      end
    end
    settle();
    monEn = 1'b1;
  endtask

  task automatic test_single_fill();
    lat = 1;
    pushFill(1'b0, 16'h0036, 1'b0, 3'd0, 16'h0000);
    i_wr = 1'b0;
    i_addr = 16'h0036;
    i_req = 1'b1;
    @(negedge clk);
    total++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fill_grant: got i_gnt=%0b d_gnt=%0b, required 1 0", i_gnt, d_gnt);
    end
    for (int k = 0; k < WORDS; k++) begin
      total++;
      if (mem_en !== 1'b1) begin
        bad++;
        $display("[TB] FAIL fill_issue: cycle %0d got mem_en=%0b, required 1", k, mem_en);
      end
      @(negedge clk);
    end
    total++;
    if (mem_en !== 1'b0 || i_done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fill_last: got mem_en=%0b i_done=%0b, required 0 1", mem_en, i_done);
    end
    i_req = 1'b0;
    @(negedge clk);
    total++;
    if (i_gnt !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fill_gnt_drop: got i_gnt=%0b, required 0", i_gnt);
    end
    #1;
    total++;
    if (expRet.size() != 0 || expReq.size() != 0) begin
      bad++;
      $display("[TB] FAIL fill_leftover: got ret=%0d req=%0d pending, required 0 0", expRet.size(), expReq.size());
    end
    settle();
  endtask

  task automatic test_write();
    req_t q;
    int seen;
    logic [7:0] order;
    lat = 1;
    q.wr = 1'b1;
    q.addr = 16'h1004;
    q.wdata = 16'hBEEF;
    expReq.push_back(q);
    d_wr = 1'b1;
    d_addr = 16'h1004;
    d_wdata = 16'hBEEF;
    d_req = 1'b1;
    @(negedge clk);
    total++;
    if ({d_gnt, d_done, mem_en, mem_wr, i_gnt} !== 5'b11110) begin
      bad++;
      $display("[TB] FAIL write_cycle: got dg/dd/en/wr/ig=%b, required 11110",
               {d_gnt, d_done, mem_en, mem_wr, i_gnt});
    end
    d_req = 1'b0;
    d_wr = 1'b0;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b0 || mem_en !== 1'b0 || d_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_end: got d_gnt=%0b mem_en=%0b d_done=%0b, required 0 0 0", d_gnt, mem_en, d_done);
    end
    pushFill(1'b1, 16'h1000, 1'b1, 3'd2, 16'hBEEF);
    d_addr = 16'h1000;
    d_req = 1'b1;
    waitDones(1, 40, seen, order);
    d_req = 1'b0;
    total++;
    if (seen != 1 || order[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL write_readback_done: got %0d pulses owner=%0b, required 1 D", seen, order[0]);
    end
    #1;
    total++;
    if (expRet.size() != 0 || expReq.size() != 0) begin
      bad++;
      $display("[TB] FAIL write_leftover: got ret=%0d req=%0d pending, required 0 0", expRet.size(), expReq.size());
    end
    settle();
  endtask

  task automatic test_contention();
    int seen;
    logic [7:0] order;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 3;
    pushFill(1'b1, 16'h0400, 1'b0, 3'd0, 16'h0000);
    pushFill(1'b0, 16'h0200, 1'b0, 3'd0, 16'h0000);
    pushFill(1'b1, 16'h0400, 1'b0, 3'd0, 16'h0000);
    pushFill(1'b0, 16'h0200, 1'b0, 3'd0, 16'h0000);
    i_addr = 16'h0200;
    d_addr = 16'h0400;
    i_wr = 1'b0;
    d_wr = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    waitDones(4, 200, seen, order);
    i_req = 1'b0;
    d_req = 1'b0;
    total++;
    if (seen != 4) begin
      bad++;
      $display("[TB] FAIL contention_count: got %0d done pulses, required 4", seen);
    end
    total++;
    if (order[3:0] !== 4'b1010) begin
      bad++;
      $display("[TB] FAIL contention_order: got %b (1=D), required 1010", order[3:0]);
    end
    #1;
    total++;
    if (expRet.size() != 0 || expReq.size() != 0) begin
      bad++;
      $display("[TB] FAIL contention_leftover: got ret=%0d req=%0d pending, required 0 0", expRet.size(), expReq.size());
    end
    settle();
  endtask

  task automatic test_req_drop();
    int issued;
    int seen;
    logic [7:0] order;
    lat = 2;
    pushFill(1'b1, 16'h0A10, 1'b0, 3'd0, 16'h0000);
    d_wr = 1'b0;
    d_addr = 16'h0A10;
    d_req = 1'b1;
    issued = 0;
    for (int k = 0; k < 20 && issued < 2; k++) begin
      @(negedge clk);
      if (mem_en) issued++;
    end
    d_req = 1'b0;
    total++;
    if (issued != 2) begin
      bad++;
      $display("[TB] FAIL drop_issue: got %0d issued, required 2", issued);
    end
    waitDones(1, 40, seen, order);
    total++;
    if (seen != 1 || order[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drop_done: got %0d pulses owner=%0b, required 1 D", seen, order[0]);
    end
    #1;
    total++;
    if (expRet.size() != 0 || expReq.size() != 0) begin
      bad++;
      $display("[TB] FAIL drop_leftover: got ret=%0d req=%0d pending, required 0 0", expRet.size(), expReq.size());
    end
    settle();
  endtask

  task automatic test_latency_sweep();
    int lats [3] = '{1, 4, 7};
    int seen;
    logic [7:0] order;
    for (int j = 0; j < 3; j++) begin
      settle();
      lat = lats[j];
      pushFill(1'b0, 16'h3456, 1'b0, 3'd0, 16'h0000);
      i_wr = 1'b0;
      i_addr = 16'h3456;
      i_req = 1'b1;
      waitDones(1, 60, seen, order);
      i_req = 1'b0;
      total++;
      if (seen != 1 || order[0] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL latency_done: lat=%0d got %0d pulses owner=%0b, required 1 I", lats[j], seen, order[0]);
      end
      #1;
      total++;
      if (expRet.size() != 0 || expReq.size() != 0) begin
        bad++;
        $display("[TB] FAIL latency_leftover: lat=%0d got ret=%0d req=%0d pending, required 0 0",
                 lats[j], expRet.size(), expReq.size());
      end
    end
    settle();
  endtask

  initial begin
    for (int w = 0; w < 32768; w++) memArr[w] = patt(15'(w));
    $display("[TB] starting mem_arbiter bench");
    test_reset();
    test_single_fill();
    test_write();
    test_contention();
    test_req_drop();
    test_latency_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
